// File: rtl/app_instr_driver.sv
// Host-to-softMC instruction driver plus read-back word serializer (256b -> 32b beats).
// Optional ACK watchdog under APP_DRV_ACK_TIMEOUT_EN; instruction path stalls on iq_full, read path on host_rd_ready.
module app_instr_driver #(
  parameter int DQ_WIDTH    = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_instr_valid,
  output logic                  host_instr_ready,
  input  logic [31:0]           host_instr,
  input  logic                  host_instr_last,
  output logic                  app_en,
  output logic [31:0]           app_instr,
  input  logic                  app_ack,
  input  logic                  iq_full,
  input  logic                  processing_iseq,
  input  logic                  rdback_fifo_empty,
  output logic                  rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0] rdback_data,
  output logic                  host_rd_valid,
  input  logic                  host_rd_ready,
  output logic [31:0]           host_rd_data,
  output logic                  host_rd_last,
  output logic                  seq_busy,
  output logic [15:0]           instr_count,
  output logic                  ack_timeout_err
);

  localparam int RD_W   = 4 * DQ_WIDTH;
  localparam int NBEATS = RD_W / 32;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SEQ_WAIT_START, SEQ_WAIT_DONE} istate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} rstate_t;

  istate_t     state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic [15:0] count_q, count_d;

`ifdef APP_DRV_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
`endif

  rstate_t           rstate_q, rstate_d;
  logic [RD_W-1:0]   sh_q, sh_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // ---------------- instruction FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

`ifdef APP_DRV_ACK_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end
`endif

  always_comb begin
    state_d          = state_q;
    instr_d          = instr_q;
    last_d           = last_q;
    count_d          = count_q;
    host_instr_ready = 1'b0;
    app_en           = 1'b0;
`ifdef APP_DRV_ACK_TIMEOUT_EN
    to_cnt_d         = '0;
    to_err_d         = to_err_q;
`endif
    case (state_q)
      IDLE: begin
        // Ready is forced low during reset even though state already reads IDLE.
        host_instr_ready = ~iq_full & ~rst;
        if (host_instr_valid && host_instr_ready) begin
          instr_d = host_instr;
          last_d  = host_instr_last;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        app_en = 1'b1;
        if (app_ack) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (!last_q)              state_d = IDLE;
          else if (processing_iseq) state_d = SEQ_WAIT_DONE;
          else                      state_d = SEQ_WAIT_START;
        end
`ifdef APP_DRV_ACK_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      SEQ_WAIT_START: begin
        if (processing_iseq) state_d = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        if (!processing_iseq) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
    endcase
  end

  assign app_instr   = instr_q;
  assign instr_count = count_q;
  assign seq_busy    = (state_q != IDLE) || (count_q != 16'd0);

`ifdef APP_DRV_ACK_TIMEOUT_EN
  assign ack_timeout_err = to_err_q;
`else
  assign ack_timeout_err = 1'b0;
`endif

  // ---------------- read-back serializer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      sh_q     <= '0;
      beat_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      sh_q     <= sh_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    rstate_d         = rstate_q;
    sh_d             = sh_q;
    beat_d           = beat_q;
    rdback_fifo_rden = 1'b0;
    host_rd_valid    = 1'b0;
    host_rd_last     = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (!rdback_fifo_empty && !rst) begin
          rdback_fifo_rden = 1'b1;
          rstate_d         = R_LOAD;
        end
      end
      R_LOAD: begin
        // FIFO output becomes valid the cycle after rden.
        sh_d     = rdback_data;
        beat_d   = '0;
        rstate_d = R_SEND;
      end
      R_SEND: begin
        host_rd_valid = 1'b1;
        host_rd_last  = (beat_q == BEAT_W'(NBEATS - 1));
        if (host_rd_ready) begin
          sh_d = sh_q >> 32;
          if (host_rd_last) begin
            beat_d   = '0;
            rstate_d = R_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Low word first: the shift register always presents the current beat in its low 32 bits.
  assign host_rd_data = sh_q[31:0];

endmodule

// File: doc/app_instr_driver.md
APP_INSTR_DRIVER -- requirements
Module: app_instr_driver

Interface
REQ-001 SHALL have parameter DQ_WIDTH, default 64, DRAM data width; read-back word is 4*DQ_WIDTH bits.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1024, cycles to wait for app_ack before flagging an error.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports host_instr_valid/host_instr_ready  in/out  1/1  host instruction handshake.
REQ-006 SHALL have ports host_instr  input  32  and host_instr_last  input  1 (marks the final instruction of a sequence).
REQ-007 SHALL have ports app_en  output  1, app_instr  output  32, app_ack  input  1  softMC command interface.
REQ-008 SHALL have ports iq_full  input  1  and processing_iseq  input  1  softMC status.
REQ-009 SHALL have ports rdback_fifo_empty  input  1, rdback_fifo_rden  output  1, rdback_data  input  4*DQ_WIDTH.
REQ-010 SHALL have ports host_rd_valid  output  1, host_rd_ready  input  1, host_rd_data  output  32, host_rd_last  output  1.
REQ-011 SHALL have ports seq_busy  output  1, instr_count  output  16, ack_timeout_err  output  1.

Function
REQ-012 Instruction FSM states: IDLE, DRIVE, SEQ_WAIT_START, SEQ_WAIT_DONE.
REQ-013 IDLE: host_instr_ready = ~iq_full; on valid&ready, latch host_instr/last into app_instr, go to DRIVE next cycle.
REQ-014 DRIVE: app_en=1, app_instr stable; on app_ack=1, app_en drops next cycle and instr_count increments (saturates at 0xFFFF).
REQ-015 After ack of a non-last instruction -> IDLE; after ack of the last instruction -> SEQ_WAIT_START.
REQ-016 SEQ_WAIT_START: wait until processing_iseq=1 (sampled the same cycle as the ack also counts), then SEQ_WAIT_DONE.
REQ-017 SEQ_WAIT_DONE: on processing_iseq=0 -> IDLE, and instr_count clears to 0 on that transition.
REQ-018 host_instr_ready SHALL be 0 in every state other than IDLE; seq_busy = (state != IDLE) or instr_count != 0.
REQ-019 iq_full rising while in DRIVE SHALL NOT withdraw app_en; only new acceptance is blocked.
REQ-020 Read-back FSM states: R_IDLE, R_LOAD, R_SEND; independent of the instruction FSM.
REQ-021 R_IDLE with rdback_fifo_empty=0: assert rdback_fifo_rden for exactly one cycle, go to R_LOAD.
REQ-022 R_LOAD: capture rdback_data (FIFO output valid one cycle after rden) into a shift register; beat index=0; -> R_SEND.
REQ-023 R_SEND: host_rd_valid=1, host_rd_data = bits[32*i+31:32*i], beat i from 0 to 4*DQ_WIDTH/32-1, low word first.
REQ-024 Beat advances only on host_rd_valid&host_rd_ready; host_rd_last=1 on the final beat; after the final beat -> R_IDLE.
REQ-025 host_rd_data/last SHALL hold stable while valid and not ready; rdback_fifo_rden never asserted outside R_IDLE.

Reset
REQ-026 On rst: both FSMs to IDLE/R_IDLE; app_en=0, app_instr=0, rdback_fifo_rden=0, host_rd_valid=0, host_rd_last=0, host_rd_data=0, instr_count=0, ack_timeout_err=0, host_instr_ready=0 while rst high.
REQ-027 Reset mid-handshake SHALL abandon the pending instruction and any partially sent read-back word without replay.

Configuration
REQ-028 Macro APP_DRV_ACK_TIMEOUT_EN defined: a counter runs in DRIVE; if it reaches ACK_TIMEOUT without app_ack, ack_timeout_err sets (sticky until rst), app_en drops, and the FSM goes to IDLE.
REQ-029 Macro undefined: no counter; DRIVE waits indefinitely; ack_timeout_err is tied to 0.

Verification
REQ-030 Three instructions 0x11,0x22,0x33(last), ack delay 2 cycles each -> three app_en pulses in order; instr_count=3; IDLE after processing_iseq 1->0; instr_count=0.
REQ-031 iq_full=1 in IDLE with host_instr_valid=1 -> host_instr_ready=0, app_en stays 0; iq_full=0 -> accepted next cycle.
REQ-032 One 256-bit read-back word 0x...08_07_..._01 (word k = k+1) with host_rd_ready=1 -> one rden pulse, 8 beats 1..8, last on beat 8.
REQ-033 Same word, host_rd_ready toggling 1,0 -> data/last held during stalls, 8 beats total, no second rden until R_IDLE.
REQ-034 APP_DRV_ACK_TIMEOUT_EN defined, ACK_TIMEOUT=16, app_ack never asserted -> ack_timeout_err=1 after 16 DRIVE cycles, app_en=0.
REQ-035 rst asserted during R_SEND beat 3 -> host_rd_valid=0 immediately; after release, next non-empty FIFO triggers a fresh rden.
